// File: rtl/fetch_pkg.sv
// Shared core constants and the fetch queue entry type.
// XLEN and NOP_INST are also consumed by decode.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request acceptance and filled
// in order by responses. Slots between rd and fill pointers are the filled ones.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clr,
   input  logic            i_alloc,
   input  logic [XLEN-1:0] i_alloc_pc,
   input  logic            i_fill,
   input  logic [XLEN-1:0] i_fill_inst,
   input  logic            i_pop,
   output logic            o_head_vld,
   output fq_entry_t       o_head,
   output logic [PW:0]     o_alloc_cnt,
   output logic [PW:0]     o_unfilled_cnt
);
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]     r_wr, r_fill, r_rd;
   logic [XLEN-1:0] r_pc   [DEPTH];
   logic [XLEN-1:0] r_inst [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_wr   <= '0;
         r_fill <= '0;
         r_rd   <= '0;
      end else begin
         if (i_alloc) r_wr   <= r_wr + 1'b1;
         if (i_fill)  r_fill <= r_fill + 1'b1;
         if (i_pop)   r_rd   <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_alloc) r_pc[r_wr[PW-1:0]]     <= i_alloc_pc;
      if (i_fill)  r_inst[r_fill[PW-1:0]] <= i_fill_inst;
   end

   assign o_head_vld     = (r_fill != r_rd);
   assign o_head.pc      = r_pc[r_rd[PW-1:0]];
   assign o_head.inst    = r_inst[r_rd[PW-1:0]];
   assign o_alloc_cnt    = r_wr - r_rd;
   assign o_unfilled_cnt = r_wr - r_fill;
endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC generation, request issue, stale-response drop
// counter, queue head to decode. FETCH_PERF_EN adds the PERF_BUBBLE counter.
module fetch
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            FLUSH,
   input  logic [XLEN-1:0] FLUSH_PC,
   input  logic            STALL,
   input  logic            MMU_WAIT,
   output logic            INST_RDEN,
   output logic [XLEN-1:0] INST_RADDR,
   input  logic            INST_RREADY,
   input  logic            INST_RVALID,
   input  logic [XLEN-1:0] INST_RDATA,
   output logic [XLEN-1:0] FETCH_PC,
   output logic [XLEN-1:0] FETCH_INST
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     PERF_BUBBLE
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

   logic [XLEN-1:0] r_fetch_pc;
   logic [PW:0]     r_drop;
   logic [PW:0]     w_drop_nxt;
   logic [PW+1:0]   w_drop_sum;
   logic [PW+1:0]   w_inflight;
   logic [PW:0]     w_alloc_cnt, w_unfilled_cnt;
   logic            w_accept, w_fill, w_drop_rsp, w_pop, w_head_vld, w_proto_err;
   fq_entry_t       w_head;

   // Stale responses still owed by memory count against capacity.
   assign w_inflight = {1'b0, w_alloc_cnt} + {1'b0, r_drop};
   assign INST_RDEN  = !RST && !FLUSH && !MMU_WAIT && (w_inflight < DEPTH_W);
   assign INST_RADDR = r_fetch_pc;
   assign w_accept   = INST_RDEN && INST_RREADY;

   assign w_drop_rsp  = INST_RVALID && (r_drop != '0);
   assign w_fill      = INST_RVALID && (r_drop == '0) && (w_unfilled_cnt != '0) && !FLUSH;
   assign w_pop       = w_head_vld && !STALL && !MMU_WAIT && !FLUSH;
   assign w_proto_err = INST_RVALID && (r_drop == '0) && (w_unfilled_cnt == '0);

   // On flush every unfilled entry becomes a response to discard, less the
   // one (stale or live) arriving this very cycle.
   always_comb begin
      w_drop_sum = {1'b0, r_drop} + {1'b0, w_unfilled_cnt};
      w_drop_nxt = r_drop;
      if (FLUSH) begin
         if (INST_RVALID && (w_drop_sum != '0)) w_drop_sum = w_drop_sum - 1'b1;
         w_drop_nxt = (w_drop_sum > DEPTH_W) ? DEPTH_W[PW:0] : w_drop_sum[PW:0];
      end else if (w_drop_rsp) begin
         w_drop_nxt = r_drop - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fetch_pc <= RESET_PC;
         r_drop     <= '0;
      end else begin
         r_drop <= w_drop_nxt;
         if (FLUSH)         r_fetch_pc <= {FLUSH_PC[XLEN-1:2], 2'b00};
         else if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .i_clk          (CLK),
      .i_rst          (RST),
      .i_clr          (FLUSH),
      .i_alloc        (w_accept),
      .i_alloc_pc     (r_fetch_pc),
      .i_fill         (w_fill),
      .i_fill_inst    (INST_RDATA),
      .i_pop          (w_pop),
      .o_head_vld     (w_head_vld),
      .o_head         (w_head),
      .o_alloc_cnt    (w_alloc_cnt),
      .o_unfilled_cnt (w_unfilled_cnt)
   );

   assign FETCH_PC   = w_head_vld ? w_head.pc   : '0;
   assign FETCH_INST = w_head_vld ? w_head.inst : NOP_INST;

   a_rsp_expected: assert property (@(posedge CLK) disable iff (RST) !w_proto_err);

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_bubble;

   always_ff @(posedge CLK) begin
      if (RST)
         r_perf_bubble <= '0;
      else if (!STALL && !MMU_WAIT && !FLUSH && !w_head_vld && (r_perf_bubble != '1))
         r_perf_bubble <= r_perf_bubble + 32'd1;
   end

   assign PERF_BUBBLE = r_perf_bubble;
`endif
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: vector table, directed corner sequences and random traffic
// against a queue-level model of requests owed by memory and words awaiting decode.
module tb_fetch;
   import fetch_pkg::*;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST, FLUSH, STALL, MMU_WAIT, INST_RDEN, INST_RREADY, INST_RVALID;
   logic [31:0] FLUSH_PC, INST_RADDR, INST_RDATA, FETCH_PC, FETCH_INST;
`ifdef FETCH_PERF_EN
   logic [31:0] PERF_BUBBLE;
`endif

   fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC), .STALL(STALL),
      .MMU_WAIT(MMU_WAIT), .INST_RDEN(INST_RDEN), .INST_RADDR(INST_RADDR),
      .INST_RREADY(INST_RREADY), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
      .FETCH_PC(FETCH_PC), .FETCH_INST(FETCH_INST)
`ifdef FETCH_PERF_EN
      , .PERF_BUBBLE(PERF_BUBBLE)
`endif
   );

   always #5 CLK = ~CLK;

   // Model: mq = requests accepted and not yet answered (stale once flushed);
   // rq = live words returned and not yet taken by decode.
   typedef struct { logic [31:0] pc; bit stale; int t; } req_t;
   req_t        mq[$];
   logic [31:0] rq[$];
   logic [31:0] next_pc, perf_exp;
   int          cyc, n_chk, n_fail;
   logic        s_rden;
   logic [31:0] s_raddr, s_pc, s_inst;

   typedef struct {
      bit stall, mmu, flush; logic [31:0] fpc; bit rready, rv;
      bit e_rden; logic [31:0] e_raddr, e_pc, e_inst;
   } vec_t;
   vec_t        vt[12];
   logic [31:0] wrap_a[4];

   function automatic logic [31:0] idata(input logic [31:0] a);
      return a ^ 32'h0000_00A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; STALL = 1'b0; MMU_WAIT = 1'b0; FLUSH = 1'b0; FLUSH_PC = '0;
      INST_RREADY = 1'b0; INST_RVALID = 1'b0; INST_RDATA = '0;
      @(posedge CLK); #4;
      chk("rst_rden", 32'(INST_RDEN), 32'h0);
      chk("rst_fetch_pc", FETCH_PC, 32'h0);
      chk("rst_fetch_inst", FETCH_INST, NOP_INST);
`ifdef FETCH_PERF_EN
      chk("rst_perf", PERF_BUBBLE, 32'h0);
`endif
      @(posedge CLK); #1;
      RST = 1'b0;
      mq.delete(); rq.delete();
      next_pc = 32'h0; perf_exp = 32'h0;
   endtask

   // One cycle: drive at posedge+1, sample and check mid-cycle, advance model.
   task automatic step(input bit stall, input bit mmu, input bit flush,
                       input logic [31:0] fpc, input bit rready, input bit rv);
      bit   take, exp_rden;
      req_t r;
      take = rv && (mq.size() > 0);
      if (take) take = (mq[0].t < cyc);
      STALL = stall; MMU_WAIT = mmu; FLUSH = flush; FLUSH_PC = fpc;
      INST_RREADY = rready; INST_RVALID = take;
      INST_RDATA  = take ? idata(mq[0].pc) : $urandom();
      #4;
      s_rden = INST_RDEN; s_raddr = INST_RADDR; s_pc = FETCH_PC; s_inst = FETCH_INST;
      exp_rden = !flush && !mmu && ((mq.size() + rq.size()) < DEPTH);
      chk("rden", 32'(s_rden), 32'(exp_rden));
      if (exp_rden) chk("raddr", s_raddr, next_pc);
      chk("fetch_pc", s_pc, (rq.size() != 0) ? rq[0] : 32'h0);
      chk("fetch_inst", s_inst, (rq.size() != 0) ? idata(rq[0]) : NOP_INST);
`ifdef FETCH_PERF_EN
      chk("perf_bubble", PERF_BUBBLE, perf_exp);
`endif
      if (!stall && !mmu && !flush && (rq.size() == 0)) perf_exp++;
      if ((rq.size() != 0) && !stall && !mmu && !flush) void'(rq.pop_front());
      if (take) begin
         r = mq.pop_front();
         if (!r.stale) rq.push_back(r.pc);
      end
      if (exp_rden && rready) begin
         mq.push_back('{next_pc, 1'b0, cyc});
         next_pc += 32'd4;
      end
      if (flush) begin
         rq.delete();
         foreach (mq[k]) mq[k].stale = 1'b1;
         next_pc = {fpc[31:2], 2'b00};
      end
      @(posedge CLK); #1;
      cyc++;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0;
      //          stall mmu   flush fpc           rdy   rv    rden  raddr         pc            inst
      vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0,        NOP_INST};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4,        32'h0,        NOP_INST};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8,        32'h0,        32'hA5};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        32'h4,        32'hA1};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'h4,        32'hA1};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h10,       32'h4,        32'hA1};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'h4,        32'hA1};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        32'hA1};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h14,       32'h8,        32'hAD};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'hC,        32'hA9};
      vt[10] = '{1'b0, 1'b0, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'hA9};
      vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h100,      32'h0,        NOP_INST};
      wrap_a[0] = 32'hFFFF_FFF8; wrap_a[1] = 32'hFFFF_FFFC; wrap_a[2] = 32'h0; wrap_a[3] = 32'h4;

      // Vector table: fill, stall with full queue, MMU wait, flush.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(vt[i].stall, vt[i].mmu, vt[i].flush, vt[i].fpc, vt[i].rready, vt[i].rv);
         chk("vec_rden", 32'(s_rden), 32'(vt[i].e_rden));
         if (vt[i].e_rden) chk("vec_raddr", s_raddr, vt[i].e_raddr);
         chk("vec_pc", s_pc, vt[i].e_pc);
         chk("vec_inst", s_inst, vt[i].e_inst);
      end

      // Streaming at 1-cycle latency: no gaps once the pipe is full.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         if (i >= 2) begin
            chk("stream_pc", s_pc, 32'((i - 2) * 4));
            chk("stream_inst", s_inst, idata(32'((i - 2) * 4)));
         end
      end

      // Flush with 3 outstanding: all three stale responses are discarded.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("flush_cap_rden", 32'(s_rden), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
         chk("flush_drop_pc", s_pc, 32'h0);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("flush_first_pc", s_pc, 32'h100);
      chk("flush_first_inst", s_inst, 32'h1A5);

      // Flush coinciding with a response, two unfilled: exactly one drop.
      do_reset();
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("flush_rv_drop_pc", s_pc, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("flush_rv_bubble_pc", s_pc, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("flush_rv_pc", s_pc, 32'h200);
      chk("flush_rv_inst", s_inst, 32'h2A5);

      // Memory not ready: address held, bubbles presented.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
         chk("hold_rden", 32'(s_rden), 32'h1);
         chk("hold_raddr", s_raddr, 32'h0);
         chk("hold_inst", s_inst, NOP_INST);
      end
`ifdef FETCH_PERF_EN
      chk("hold_perf", PERF_BUBBLE, 32'd4);
`endif

      // Address wrap after a misaligned redirect.
      do_reset();
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         chk("wrap_rden", 32'(s_rden), 32'h1);
         chk("wrap_raddr", s_raddr, wrap_a[i]);
      end

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(9) < 3, $urandom_range(9) < 1, $urandom_range(99) < 3,
              ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom(),
              $urandom_range(9) < 7, $urandom_range(9) < 6);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Generates sequential fetch addresses and issues in-order requests to the instruction memory/MMU port.
- Holds returned words with their PCs in a small in-order queue, and presents one {PC, INST} pair per cycle to decode's PC/INST inputs.
- On FLUSH, redirects to FLUSH_PC and discards every in-flight response.

Parameters:
DEPTH, 4, queue entries and max outstanding+queued requests; power of two, >=2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock, synchronous active-high reset
FLUSH  in  1  pipeline flush / redirect (same signal decode receives)
FLUSH_PC  in  32  redirect target, sampled when FLUSH=1
STALL  in  1  downstream stall (same as decode)
MMU_WAIT  in  1  MMU busy (same as decode)
INST_RDEN  out  1  fetch request valid
INST_RADDR  out  32  fetch address, word aligned
INST_RREADY  in  1  memory accepts request this cycle
INST_RVALID  in  1  response valid; responses return in request order, at most one per cycle
INST_RDATA  in  32  response instruction word
FETCH_PC  out  32  to decode PC
FETCH_INST  out  32  to decode INST

Behaviour:
- Reset (RST=1 at posedge):
  - fetch_pc<=RESET_PC; queue empty; drop counter 0.
  - INST_RDEN=0 while RST=1.
  - FETCH_PC=0, FETCH_INST=32'h0000_0013 (NOP).
- Queue entry = {pc, inst, filled}:
  - An entry is allocated at request acceptance (INST_RDEN && INST_RREADY), stamped with INST_RADDR, filled=0.
  - The next response not being dropped fills the oldest unfilled entry.
- Request issue:
  - INST_RDEN = !RST && !FLUSH && !MMU_WAIT && (allocated + drop) < DEPTH.
  - INST_RADDR = fetch_pc.
  - On acceptance, fetch_pc <= fetch_pc+4, wrapping 32'hFFFF_FFFC -> 0.
  - INST_RADDR must stay stable while INST_RDEN=1 and INST_RREADY=0.
- Output (combinational from head):
  - Head filled: FETCH_PC=head.pc, FETCH_INST=head.inst.
  - Otherwise: FETCH_PC=0, FETCH_INST=NOP (bubble).
- Pop: head filled && !STALL && !MMU_WAIT && !FLUSH. Decode latches exactly then, so every instruction is delivered once.
  - A bubble is never popped.
  - A response arriving the same cycle is not forwarded; it is visible the next cycle. Minimum latency from response to FETCH_* is 1 cycle.
- Occupancy:
  - Allocated count updates with +issue -pop in the same cycle.
  - The issue check uses pre-update values, so a pop does not free a slot until the next cycle.
- FLUSH (priority over everything except RST):
  - Queue cleared, fetch_pc<=FLUSH_PC, no issue, no pop.
  - drop <= drop + (number of allocated-unfilled entries) - (INST_RVALID ? 1 : 0).
  - FLUSH_PC[1:0] is ignored (forced to 0).
- Drop: while drop>0, each INST_RVALID decrements drop and is discarded; it fills nothing.
- Back-to-back FLUSH accumulates drop; drop never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- A response with no unfilled entry and drop=0 is a protocol error: ignore it (assertion in simulation).
- MMU_WAIT: blocks both issue and pop; responses still fill entries.

Optional Feature:
- FETCH_PERF_EN defined: adds output PERF_BUBBLE[31:0].
  - Counts cycles where !STALL && !MMU_WAIT && !FLUSH && head not filled.
  - Reset to 0; saturates at 32'hFFFF_FFFF.
- FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared core package/header holds NOP_INST=32'h0000_0013, the default RESET_PC, and the XLEN=32 width constant (also used by decode).
- One sub-module, fetch_queue: DEPTH-entry in-order buffer with alloc/fill/pop ports, flush clear, and an unfilled-count output.
- The top level keeps the PC counter, issue logic and drop counter.

Test Plan:
- Reset then INST_RREADY=1, 1-cycle response latency, data=addr^0xA5 -> FETCH_PC sequence 0,4,8,… with matching INST, no gaps after pipeline fill.
- STALL held 3 cycles with queue full -> INST_RDEN=0 once allocated=4; FETCH_PC/FETCH_INST stable; no instruction lost or duplicated after release.
- 3 outstanding requests (response latency 5), FLUSH with FLUSH_PC=0x100 -> drop=3; the 3 stale responses are discarded; the first delivered FETCH_PC=0x100.
- FLUSH in the same cycle as an INST_RVALID with 2 unfilled entries -> drop=1; the next response is dropped, the following one fills the entry for FLUSH_PC.
- INST_RREADY=0 for 4 cycles -> INST_RADDR held constant; bubbles give FETCH_INST=0x13, FETCH_PC=0; with FETCH_PERF_EN, PERF_BUBBLE increments by 4+pipeline fill.
- FLUSH_PC=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4 issued in order.
